// File: rtl/adc_scan_pkg.sv
// ============================================================
// adc_scan_pkg : shared types and helpers for the ADC scan scheduler
// Rev 1.0
// ============================================================
`default_nettype none

package adc_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int RES_W  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DONE = 3'd2,
    STORE     = 3'd3,
    NEXT      = 3'd4,
    HOLD      = 3'd5
  } scan_state_e;

  // Lowest set mask bit at or above 'from'; MSB of the result flags a hit.
  function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] mask,
                                            input logic [CH_W:0]     from);
    logic [CH_W:0] res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) res = {1'b1, CH_W'(i)};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_result_file.sv
// ============================================================
// adc_result_file : per-channel result registers with valid bits,
// one write port and one registered read port (read-before-write)
// Rev 1.0
// ============================================================
`default_nettype none

module adc_result_file
  import adc_scan_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_addr,
  input  logic [RES_W-1:0] wr_data,
  input  logic [CH_W-1:0]  rd_addr,
  output logic [RES_W-1:0] rd_data,
  output logic             rd_valid
);

  logic [RES_W-1:0]  data_q [NUM_CH];
  logic [RES_W-1:0]  data_d [NUM_CH];
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [RES_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_en) begin
      data_d[wr_addr]  = wr_data;
      valid_d[wr_addr] = 1'b1;
    end
    rd_data_d  = data_q[rd_addr];
    rd_valid_d = valid_q[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q     <= '{default: '0};
      valid_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: rtl/adc_scan_scheduler.sv
// ============================================================
// adc_scan_scheduler : walks an enabled-channel mask, issues ADC
// conversions over req/done and repeats the scan on a period
// Rev 1.0
// ============================================================
`default_nettype none

module adc_scan_scheduler
  import adc_scan_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                scan_en,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic [PERIOD_W-1:0] scan_period,
  output logic                conv_req,
  output logic [CH_W-1:0]     conv_addr,
  input  logic                conv_done,
  input  logic [RES_W-1:0]    conv_data,
  output logic                sample_valid,
  output logic [CH_W-1:0]     sample_ch,
  output logic [RES_W-1:0]    sample_data,
  output logic                scan_done,
  output logic                busy,
  input  logic [CH_W-1:0]     rd_addr,
  output logic [RES_W-1:0]    rd_data,
  output logic                rd_valid,
  input  logic                err_clr,
  output logic                err_timeout,
  output logic [CH_W-1:0]     err_ch
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  scan_state_e         state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]     next_ch_q, next_ch_d;
  logic                next_vld_q, next_vld_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [TO_W-1:0]     timer_q, timer_d;
  logic                conv_req_q, conv_req_d;
  logic [CH_W-1:0]     conv_addr_q, conv_addr_d;
  logic                sample_valid_q, sample_valid_d;
  logic [CH_W-1:0]     sample_ch_q, sample_ch_d;
  logic [RES_W-1:0]    sample_data_q, sample_data_d;
  logic                scan_done_q, scan_done_d;
  logic                busy_q, busy_d;
  logic                err_timeout_q, err_timeout_d;
  logic [CH_W-1:0]     err_ch_q, err_ch_d;

  logic [CH_W:0]       first_ch;
  logic [CH_W:0]       lookahead;
  logic                start_scan;
  logic                timeout_hit;

  assign first_ch  = find_ch(ch_enable, '0);
  assign lookahead = find_ch(mask_q, {1'b0, cur_ch_q} + (CH_W+1)'(1));

  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    cur_ch_d       = cur_ch_q;
    next_ch_d      = next_ch_q;
    next_vld_d     = next_vld_q;
    period_d       = (period_q != '0) ? period_q - PERIOD_W'(1) : '0;
    timer_d        = timer_q;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch_q;
    sample_data_d  = sample_data_q;
    scan_done_d    = 1'b0;
    err_timeout_d  = err_timeout_q;
    err_ch_d       = err_ch_q;
    start_scan     = 1'b0;
    timeout_hit    = 1'b0;

    case (state_q)
      IDLE: start_scan = scan_en && first_ch[CH_W];
      REQ: begin
        state_d = WAIT_DONE;
        timer_d = '0;
      end
      // The following channel is resolved here so scan_done can coincide
      // with the last sample_valid.
      WAIT_DONE: begin
        if (conv_done) begin
          state_d        = STORE;
          sample_valid_d = 1'b1;
          sample_ch_d    = cur_ch_q;
          sample_data_d  = conv_data;
          next_ch_d      = lookahead[CH_W-1:0];
          next_vld_d     = lookahead[CH_W];
          scan_done_d    = !lookahead[CH_W];
        end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = NEXT;
          next_ch_d   = lookahead[CH_W-1:0];
          next_vld_d  = lookahead[CH_W];
          scan_done_d = !lookahead[CH_W];
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      STORE, NEXT: begin
        if (next_vld_q) begin
          state_d  = REQ;
          cur_ch_d = next_ch_q;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (period_q <= PERIOD_W'(1)) begin
          if (scan_en && first_ch[CH_W]) start_scan = 1'b1;
          else                           state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_scan) begin
      state_d  = REQ;
      mask_d   = ch_enable;
      cur_ch_d = first_ch[CH_W-1:0];
      period_d = scan_period;
    end

    // A timeout arriving with err_clr keeps the flag set.
    if (timeout_hit) begin
      err_timeout_d = 1'b1;
      if (!err_timeout_q) err_ch_d = cur_ch_q;
    end else if (err_clr) begin
      err_timeout_d = 1'b0;
    end

    conv_req_d  = (state_d == REQ) || (state_d == WAIT_DONE);
    conv_addr_d = cur_ch_d;
    busy_d      = conv_req_d || (state_d == STORE) || (state_d == NEXT);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      mask_q         <= '0;
      cur_ch_q       <= '0;
      next_ch_q      <= '0;
      next_vld_q     <= 1'b0;
      period_q       <= '0;
      timer_q        <= '0;
      conv_req_q     <= 1'b0;
      conv_addr_q    <= '0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_data_q  <= '0;
      scan_done_q    <= 1'b0;
      busy_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_ch_q       <= '0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      cur_ch_q       <= cur_ch_d;
      next_ch_q      <= next_ch_d;
      next_vld_q     <= next_vld_d;
      period_q       <= period_d;
      timer_q        <= timer_d;
      conv_req_q     <= conv_req_d;
      conv_addr_q    <= conv_addr_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      sample_data_q  <= sample_data_d;
      scan_done_q    <= scan_done_d;
      busy_q         <= busy_d;
      err_timeout_q  <= err_timeout_d;
      err_ch_q       <= err_ch_d;
    end
  end

  adc_result_file u_result_file (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (state_q == STORE),
    .wr_addr  (sample_ch_q),
    .wr_data  (sample_data_q),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  assign conv_req     = conv_req_q;
  assign conv_addr    = conv_addr_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign scan_done    = scan_done_q;
  assign busy         = busy_q;
  assign err_timeout  = err_timeout_q;
  assign err_ch       = err_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_scan_scheduler.sv
// ============================================================
// tb_adc_scan_scheduler : directed bench with a behavioural ADC responder
// Rev 1.0
// ============================================================
`default_nettype none

module tb_adc_scan_scheduler;

  logic        clock;
  logic        reset;
  logic        scan_en;
  logic [7:0]  ch_enable;
  logic [15:0] scan_period;
  logic        conv_req;
  logic [2:0]  conv_addr;
  logic        conv_done;
  logic [7:0]  conv_data;
  logic        sample_valid;
  logic [2:0]  sample_ch;
  logic [7:0]  sample_data;
  logic        scan_done;
  logic        busy;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        err_clr;
  logic        err_timeout;
  logic [2:0]  err_ch;

  adc_scan_scheduler dut (
    .clock(clock), .reset(reset), .scan_en(scan_en), .ch_enable(ch_enable),
    .scan_period(scan_period), .conv_req(conv_req), .conv_addr(conv_addr),
    .conv_done(conv_done), .conv_data(conv_data), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data), .scan_done(scan_done),
    .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .err_clr(err_clr), .err_timeout(err_timeout), .err_ch(err_ch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ADC responder: answers 20 cycles into a request with {addr,4'h0}^data_xor
  localparam int ADC_DLY = 20;
  logic [7:0] adc_ignore = 8'h00;
  logic [7:0] data_xor   = 8'h00;
  int         adc_cnt    = 0;

  initial begin
    conv_done = 1'b0;
    conv_data = 8'h00;
    forever begin
      @(negedge clock);
      conv_done = 1'b0;
      if (reset && conv_req && !adc_ignore[conv_addr]) begin
        adc_cnt++;
        if (adc_cnt == ADC_DLY) begin
          conv_done = 1'b1;
          conv_data = {conv_addr, 5'b0} >> 1 ^ data_xor;
          adc_cnt   = 0;
        end
      end else begin
        adc_cnt = 0;
      end
    end
  end

  // Passive monitor
  logic [2:0]  req_log [$];
  logic [10:0] samp_log[$];
  int          done_log[$];
  int          cyc    = 0;
  int          ch3_hi = 0;
  logic        prev_req = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (conv_req && !prev_req) req_log.push_back(conv_addr);
      if (conv_req && conv_addr == 3'd3) ch3_hi++;
      prev_req = conv_req;
      if (sample_valid) samp_log.push_back({sample_ch, sample_data});
      if (scan_done) done_log.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic       valid;
  } rd_vec_t;
  rd_vec_t tbl[8];

  task automatic run_rd_table(input string name);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock) rd_addr = tbl[i].addr;
      @(negedge clock);
      check($sformatf("%s_data%0d", name, i), rd_data, tbl[i].data);
      check($sformatf("%s_valid%0d", name, i), rd_valid, tbl[i].valid);
    end
  endtask

  task automatic wait_dones(input int n, input int max_cyc, input string name);
    int t;
    t = 0;
    while (done_log.size() < n && t < max_cyc) begin
      @(negedge clock);
      t++;
    end
    check(name, done_log.size() >= n, 1);
  endtask

  task automatic clear_logs();
    req_log.delete();
    samp_log.delete();
    done_log.delete();
  endtask

  task automatic pulse_scan(input logic [7:0] mask);
    @(negedge clock);
    ch_enable = mask;
    scan_en   = 1'b1;
    @(negedge clock);
    scan_en   = 1'b0;
  endtask

  initial begin
    int t;
    reset = 1'b0; scan_en = 1'b0; ch_enable = 8'h00; scan_period = 16'd0;
    rd_addr = 3'd0; err_clr = 1'b0;

    // ---------------- reset state
    repeat (3) @(negedge clock);
    check("rst_conv_req", conv_req, 0);
    check("rst_busy", busy, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_rd_valid", rd_valid, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // ---------------- mask 0x05, period 0, back-to-back
    clear_logs();
    ch_enable = 8'h05; scan_period = 16'd0; scan_en = 1'b1;
    @(posedge clock); #1;
    check("a_req_latency", conv_req, 1);
    check("a_first_addr", conv_addr, 0);
    check("a_busy", busy, 1);
    t = 0;
    while (!(sample_valid && sample_ch == 3'd2) && t < 200) begin
      @(negedge clock); t++;
    end
    check("a_last_done_with_sample", scan_done, 1);
    check("a_busy_in_last", busy, 1);
    @(negedge clock);
    check("a_busy_fall", busy, 0);
    wait_dones(2, 200, "a_two_scans");
    scan_en = 1'b0;
    repeat (200) @(negedge clock);
    check("a_req_count", req_log.size(), 4);
    check("a_req1", req_log[1], 2);
    check("a_req2", req_log[2], 0);
    check("a_samp0", samp_log[0], {3'd0, 8'h00});
    check("a_samp1", samp_log[1], {3'd2, 8'h20});

    // ---------------- mask 0xFF, period 500
    clear_logs();
    ch_enable = 8'hFF; scan_period = 16'd500; scan_en = 1'b1;
    wait_dones(3, 2000, "b_three_scans");
    scan_en = 1'b0;
    check("b_period1", done_log[1] - done_log[0], 500);
    check("b_period2", done_log[2] - done_log[1], 500);
    for (int i = 0; i < 8; i++) check($sformatf("b_order%0d", i), samp_log[i][10:8], i);
    repeat (600) @(negedge clock);
    for (int i = 0; i < 8; i++) tbl[i] = '{addr: 3'(i), data: 8'(i * 16), valid: 1'b1};
    run_rd_table("b_rd");

    // ---------------- read ch5 while it is being stored
    clear_logs();
    data_xor = 8'h0F; rd_addr = 3'd5; scan_period = 16'd0;
    ch_enable = 8'h20; scan_en = 1'b1;
    t = 0;
    while (!sample_valid && t < 100) begin
      @(negedge clock); t++;
    end
    scan_en = 1'b0;
    check("c_sample_data", sample_data, 8'h5F);
    check("c_rd_before", rd_data, 8'h50);
    @(negedge clock);
    check("c_rd_same_cycle_old", rd_data, 8'h50);
    @(negedge clock);
    check("c_rd_new", rd_data, 8'h5F);
    data_xor = 8'h00;
    repeat (20) @(negedge clock);

    // ---------------- scan_en dropped during ch1
    clear_logs();
    ch_enable = 8'h07; scan_en = 1'b1;
    t = 0;
    while (!(conv_req && conv_addr == 3'd1) && t < 100) begin
      @(negedge clock); t++;
    end
    scan_en = 1'b0;
    repeat (150) @(negedge clock);
    check("d_req_count", req_log.size(), 3);
    check("d_last_req", req_log[2], 2);
    check("d_done_count", done_log.size(), 1);
    check("d_idle_req", conv_req, 0);
    check("d_idle_busy", busy, 0);

    // ---------------- ch3 never answers, mask 0x18
    clear_logs();
    ch3_hi = 0; adc_ignore = 8'h08;
    pulse_scan(8'h18);
    wait_dones(1, 3000, "e_scan");
    check("e_err", err_timeout, 1);
    check("e_err_ch", err_ch, 3);
    check("e_req_high_cycles", ch3_hi, 1025);
    check("e_samp_count", samp_log.size(), 1);
    check("e_samp_ch4", samp_log[0], {3'd4, 8'h40});
    @(negedge clock) rd_addr = 3'd3;
    @(negedge clock);
    check("e_res3_kept", rd_data, 8'h30);

    // second timeout keeps the first channel
    clear_logs();
    adc_ignore = 8'h20;
    pulse_scan(8'h20);
    wait_dones(1, 3000, "e2_scan");
    check("e2_err", err_timeout, 1);
    check("e2_err_ch_first", err_ch, 3);
    check("e2_no_sample", samp_log.size(), 0);

    // err_clr held through a new timeout
    @(negedge clock);
    err_clr = 1'b1; ch_enable = 8'h20; scan_en = 1'b1;
    @(negedge clock);
    scan_en = 1'b0;
    check("e3_clr", err_timeout, 0);
    t = 0;
    while (!err_timeout && t < 1200) begin
      @(negedge clock); t++;
    end
    check("e3_set_despite_clr", err_timeout, 1);
    check("e3_err_ch", err_ch, 5);
    err_clr = 1'b0;
    @(negedge clock);
    check("e3_sticky", err_timeout, 1);
    repeat (30) @(negedge clock);

    // ---------------- reset while waiting for done
    adc_ignore = 8'h01;
    ch_enable = 8'h01; scan_en = 1'b1;
    repeat (10) @(negedge clock);
    scan_en = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    check("f_conv_req", conv_req, 0);
    check("f_busy", busy, 0);
    check("f_err", err_timeout, 0);
    check("f_err_ch", err_ch, 0);
    check("f_rd_valid", rd_valid, 0);
    @(negedge clock);
    adc_ignore = 8'h00;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) tbl[i] = '{addr: 3'(7 - i), data: 8'h00, valid: 1'b0};
    run_rd_table("f_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_scan_scheduler.md
# adc_scan_scheduler

Sequences the ADC conversion FSM across its eight analog channels so the rest of the design does not drive `start`/`address` by hand. Walks an enabled-channel mask in ascending order, issues one conversion request per channel over a req/done handshake, stores each 8-bit result in a per-channel result file and repeats the scan on a programmable period. Sits between the host/UART register logic and the existing ADC conversion FSM, replacing the static `selectInput` path.

## Interface
- `NUM_CH`, 8, number of ADC channels; channel index width `CH_W` = 3.
- `PERIOD_W`, 16, width of the scan-period counter.
- `TIMEOUT`, 1024, max cycles to wait for `conv_done` before aborting a channel.

- `clock`  in  1  single system clock, all logic rising-edge.
- `reset`  in  1  synchronous, active-low; sampled on `clock`.
- `scan_en`  in  1  level; enables periodic scanning.
- `ch_enable`  in  8  channel mask, latched at scan start.
- `scan_period`  in  16  cycles from one scan start to the next; 0 = back-to-back.
- `conv_req`  out  1  conversion request to ADC FSM.
- `conv_addr`  out  3  channel for current request; drives ADC `address`.
- `conv_done`  in  1  one-cycle pulse from ADC FSM, result valid.
- `conv_data`  in  8  conversion result, valid with `conv_done`.
- `sample_valid`  out  1  one-cycle pulse per stored result.
- `sample_ch` / `sample_data`  out  3 / 8  channel and data for `sample_valid`.
- `scan_done`  out  1  one-cycle pulse at end of each scan.
- `busy`  out  1  high while a scan is in progress.
- `rd_addr`  in  3  result-file read address.
- `rd_data` / `rd_valid`  out  8 / 1  registered read data, valid bit of that channel.
- `err_clr`  in  1  clears `err_timeout`.
- `err_timeout` / `err_ch`  out  1 / 3  sticky timeout flag, channel of first timeout.

## Operation
- States: IDLE, REQ, WAIT_DONE, STORE, NEXT, HOLD (period wait).
- IDLE: if `scan_en`=1 and `ch_enable`≠0, latch mask, load period counter, go to channel search; mask=0 stays in IDLE, no `scan_done`.
- Channel search: lowest set bit ≥ current index in latched mask; first channel of a scan starts search at 0.
- REQ/WAIT_DONE: `conv_req`=1, `conv_addr` stable, held until `conv_done` sampled high; timeout counter runs.
- STORE: write `conv_data` to result file[ch], set valid[ch], pulse `sample_valid`.
- NEXT: next enabled channel → REQ; none left → pulse `scan_done`, go to HOLD.
- HOLD: wait until period counter expires; then if `scan_en`=1 start new scan (relatch mask), else IDLE. Scan longer than period → new scan starts immediately, never overlaps.
- `scan_en` dropped mid-scan: current scan completes, then IDLE.
- Timeout: `TIMEOUT` cycles in WAIT_DONE without `conv_done` → drop `conv_req`, set `err_timeout` (if already set, `err_ch` keeps first value), no store, no `sample_valid`, continue to next channel. `err_clr` and a new timeout in same cycle → flag stays set.
- `conv_done` outside WAIT_DONE ignored.
- Period counter: PERIOD_W-bit down-counter, no wrap; `scan_period` sampled at scan start.
- Reset: state IDLE, all outputs 0, result file data and valid bits 0, error cleared.

## Timing
- `scan_en` sampled high at edge N in IDLE → `conv_req`=1 from N+1.
- `conv_done` sampled at edge K → `sample_valid`, result write, `conv_req`=0 at K+1; next channel `conv_req`=1 at K+2.
- Last channel: `scan_done` pulses in same cycle as its `sample_valid`; `busy` falls the cycle after.
- Read port: `rd_data`/`rd_valid` one cycle after `rd_addr`; read and write same channel same cycle returns old value.

## Structure
- Package `adc_scan_pkg`: state enum, `NUM_CH`, `CH_W`, result width 8.
- Sub-module `adc_result_file`: 8x8 data + valid registers, one write port, one registered read port.

## Test plan
- Mask 0x05, period 0, ADC model done after 20 cycles with data=ch*16 → requests on ch0, ch2 only; `sample_data` 0x00, 0x20; `scan_done` after ch2; back-to-back rescan.
- Mask 0xFF, period 500 → `scan_done` every 500 cycles exactly; results 0..7 all `rd_valid`=1.
- ADC model never answers ch3, mask 0x18 → `err_timeout`=1, `err_ch`=3 after 1024 cycles, ch4 still converted, result[3] unchanged.
- `scan_en` dropped during ch1 of mask 0x07 → ch2 completes, `scan_done`, IDLE, no further `conv_req`.
- `reset`=0 asserted in WAIT_DONE → next edge all outputs 0, `rd_valid`=0 for every channel.
- Read ch5 in same cycle as its STORE → old value returned; next read returns new.
